// File: rtl/ahblite_spi_pkg.sv
// Shared definitions for the AHB-Lite SPI transmitter: engine states,
// register offsets and STATUS register layout.
package ahblite_spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } spi_state_t;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 3;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic full,
                                                input logic empty,
                                                input logic [STAT_COUNT_W-1:0] count);
        logic [31:0] word;
        word = '0;
        word[STAT_BUSY]  = busy;
        word[STAT_FULL]  = full;
        word[STAT_EMPTY] = empty;
        word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return word;
    endfunction

endpackage

// File: rtl/ahblite_spi_tx_if.sv
// AHB-Lite subordinate-side signal bundle for the SPI transmitter.
interface ahblite_spi_tx_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised; push when full and
// pop when empty are ignored so callers may assert them unconditionally.
module spi_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahblite_spi_tx.sv
// AHB-Lite subordinate that queues byte writes and shifts them out on an
// SPI mode-0 master port, MSB first, one CS_N frame per byte.
module ahblite_spi_tx
    import ahblite_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahblite_spi_tx_if.slave   bus,
    output logic              SPI_SCLK,
    output logic              SPI_MOSI,
    output logic              SPI_CS_N
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             dp_valid;
    logic             dp_write;
    logic [1:0]       dp_off;
    logic             wr_txdata;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [2:0]       count_sat;
    logic             busy;

    spi_state_t       state;
    spi_state_t       state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_next;
    logic [7:0]       shreg;
    logic [7:0]       sh_next;
    logic             div_done;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0],
                               bus.HSIZE, bus.HPROT, bus.HWDATA[31:8]};

    // Only NONSEQ/SEQ transfers accepted while the bus is ready open a data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= '0;
        end else if (bus.HREADY) begin
            dp_valid <= bus.HSEL && bus.HTRANS[1];
            dp_write <= bus.HWRITE;
            dp_off   <= bus.HADDR[3:2];
        end
    end

    assign wr_txdata     = dp_valid && dp_write && (dp_off == OFF_TXDATA);
    assign push          = wr_txdata && !fifo_full;
    assign bus.HREADYOUT = !(wr_txdata && fifo_full);
    assign bus.HRESP     = 1'b0;

    spi_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .push_data (bus.HWDATA[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy = (state != IDLE) || !fifo_empty;

    always_comb begin
        count_sat = 3'(fifo_count);
        if (32'(fifo_count) > 32'd7) begin
            count_sat = 3'd7;
        end
    end

    always_comb begin
        bus.HRDATA = '0;
        if (dp_valid && !dp_write && (dp_off == OFF_STATUS)) begin
            bus.HRDATA = status_word(busy, fifo_full, fifo_empty, count_sat);
        end
    end

    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        sh_next    = shreg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                div_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sh_next    = fifo_data;
                    bit_next   = 3'd7;
                    state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_done) begin
                    div_next   = '0;
                    state_next = SHIFT_HI;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_done) begin
                    div_next = '0;
                    if (bit_cnt == 3'd0) begin
                        state_next = GAP;
                    end else begin
                        sh_next    = {shreg[6:0], 1'b0};
                        bit_next   = bit_cnt - 1'b1;
                        state_next = SHIFT_LO;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_done) begin
                    div_next   = '0;
                    state_next = IDLE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SPI pins are registered from the next state so they line up with it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            SPI_SCLK <= 1'b0;
            SPI_MOSI <= 1'b0;
            SPI_CS_N <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            shreg    <= sh_next;
            SPI_SCLK <= (state_next == SHIFT_HI);
            SPI_CS_N <= !((state_next == SHIFT_LO) || (state_next == SHIFT_HI));
            if (state_next == SHIFT_LO) begin
                SPI_MOSI <= sh_next[7];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_spi_tx.sv
// Directed bench for ahblite_spi_tx: register/ignored-traffic vector table
// plus hand-written sequences for frame timing, back-pressure and reset.
module tb_ahblite_spi_tx;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        hready;
    } xfer_t;

    typedef struct {
        string       name;
        xfer_t       x;
        logic [31:0] exp_rdata;
        logic [31:0] exp_status;
    } vec_t;

    logic HCLK;
    logic HRESET;
    logic SPI_SCLK;
    logic SPI_MOSI;
    logic SPI_CS_N;
    logic hready_force;

    int total = 0;
    int bad   = 0;

    xfer_t       xq[$];
    logic [31:0] rd_res [16];
    int          wait_res [16];

    logic        rx_bits[$];
    logic [7:0]  rx_bytes[$];
    logic [7:0]  mon_sh;
    int          mon_cnt;

    ahblite_spi_tx_if bus();

    assign bus.HREADY = hready_force & bus.HREADYOUT;

    ahblite_spi_tx #(
        .FIFO_DEPTH (4),
        .CLK_DIV    (4)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus),
        .SPI_SCLK (SPI_SCLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_CS_N (SPI_CS_N)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: sample MOSI on SCLK rise, drop partial bytes when CS_N rises.
    always @(posedge SPI_SCLK or posedge SPI_CS_N) begin
        if (SPI_CS_N) begin
            mon_cnt <= 0;
        end else begin
            rx_bits.push_back(SPI_MOSI);
            mon_sh <= {mon_sh[6:0], SPI_MOSI};
            if (mon_cnt == 7) begin
                rx_bytes.push_back({mon_sh[6:0], SPI_MOSI});
                mon_cnt <= 0;
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    function automatic xfer_t mkx(input logic sel, input logic [1:0] trans,
                                  input logic [31:0] addr, input logic write,
                                  input logic [31:0] wdata, input logic hready);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr;
        x.write = write; x.wdata = wdata; x.hready = hready;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs the queued transfers pipelined on the bus, honouring HREADYOUT.
    task automatic applyStimulus();
        int   ap;
        int   dp;
        int   nxt;
        int   guard;
        int   n;
        logic rdy_prev;
        n = xq.size();
        ap = -1; dp = -1; nxt = 0; guard = 0; rdy_prev = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_res[i] = '0;
            wait_res[i] = 0;
        end
        forever begin
            @(negedge HCLK);
            guard++;
            if (rdy_prev) begin
                dp = ap;
                if (nxt < n) begin
                    ap = nxt;
                    nxt++;
                end else begin
                    ap = -1;
                end
                if (ap >= 0) begin
                    bus.HSEL = xq[ap].sel;
                    bus.HTRANS = xq[ap].trans;
                    bus.HADDR = xq[ap].addr;
                    bus.HWRITE = xq[ap].write;
                    hready_force = xq[ap].hready;
                end else begin
                    bus.HSEL = 1'b0;
                    bus.HTRANS = 2'b00;
                    bus.HADDR = '0;
                    bus.HWRITE = 1'b0;
                    hready_force = 1'b1;
                end
                bus.HWDATA = (dp >= 0) ? xq[dp].wdata : 32'h0;
            end
            rdy_prev = bus.HREADYOUT;
            if (dp >= 0) begin
                if (!rdy_prev) wait_res[dp]++;
                else rd_res[dp] = bus.HRDATA;
            end
            if (rdy_prev && ap < 0) break;
            if (guard >= 1000) begin
                total++;
                bad++;
                $display("[TB] FAIL bus_timeout: got %0d cycles limit 1000", guard);
                break;
            end
        end
    endtask

    task automatic readStatus(output logic [31:0] data);
        xq.delete();
        xq.push_back(mkx(1'b1, 2'b10, 32'h5000_0014, 1'b0, 32'h0, 1'b1));
        applyStimulus();
        data = rd_res[0];
    endtask

    task automatic writeByte(input logic [31:0] data);
        xq.delete();
        xq.push_back(mkx(1'b1, 2'b10, 32'h5000_0010, 1'b1, data, 1'b1));
        applyStimulus();
    endtask

    vec_t        vecs [12];
    logic [7:0]  a5;
    logic [7:0]  six [6];
    logic [31:0] st;
    int          cnt;

    initial begin
        HRESET = 1'b1;
        hready_force = 1'b1;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
        bus.HPROT = 4'b0011; bus.HWRITE = 1'b0; bus.HWDATA = '0;
        mon_sh = '0; mon_cnt = 0;

        vecs[0]  = '{"rd_status_reset", mkx(1, 2'b10, 32'h5000_0014, 0, 32'h0, 1), 32'h4, 32'h4};
        vecs[1]  = '{"rd_txdata",       mkx(1, 2'b10, 32'h5000_0010, 0, 32'h0, 1), 32'h0, 32'h4};
        vecs[2]  = '{"rd_off8",         mkx(1, 2'b10, 32'h5000_0018, 0, 32'h0, 1), 32'h0, 32'h4};
        vecs[3]  = '{"rd_offC",         mkx(1, 2'b10, 32'h5000_001C, 0, 32'h0, 1), 32'h0, 32'h4};
        vecs[4]  = '{"wr_off8",         mkx(1, 2'b10, 32'h5000_0018, 1, 32'h55, 1), 32'h0, 32'h4};
        vecs[5]  = '{"wr_offC",         mkx(1, 2'b10, 32'h5000_001C, 1, 32'h66, 1), 32'h0, 32'h4};
        vecs[6]  = '{"wr_status",       mkx(1, 2'b10, 32'h5000_0014, 1, 32'h77, 1), 32'h0, 32'h4};
        vecs[7]  = '{"idle_wr_txdata",  mkx(1, 2'b00, 32'h5000_0010, 1, 32'h11, 1), 32'h0, 32'h4};
        vecs[8]  = '{"busy_wr_txdata",  mkx(1, 2'b01, 32'h5000_0010, 1, 32'h22, 1), 32'h0, 32'h4};
        vecs[9]  = '{"nosel_wr_txdata", mkx(0, 2'b10, 32'h5000_0010, 1, 32'h33, 1), 32'h0, 32'h4};
        vecs[10] = '{"hrdylo_wr_txdata",mkx(1, 2'b10, 32'h5000_0010, 1, 32'h44, 0), 32'h0, 32'h4};
        vecs[11] = '{"seq_rd_status",   mkx(1, 2'b11, 32'h5000_0014, 0, 32'h0, 1), 32'h4, 32'h4};

        repeat (3) @(negedge HCLK);
        checkOutput("reset_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("reset_hrdata", bus.HRDATA, 32'h0);
        checkOutput("reset_hresp", 32'(bus.HRESP), 32'h0);
        checkOutput("reset_cs_n", 32'(SPI_CS_N), 32'h1);
        checkOutput("reset_sclk", 32'(SPI_SCLK), 32'h0);
        checkOutput("reset_mosi", 32'(SPI_MOSI), 32'h0);
        HRESET = 1'b0;
        repeat (2) @(negedge HCLK);

        for (int i = 0; i < 12; i++) begin
            xq.delete();
            xq.push_back(vecs[i].x);
            applyStimulus();
            checkOutput({vecs[i].name, "_rdata"}, rd_res[0], vecs[i].exp_rdata);
            readStatus(st);
            checkOutput({vecs[i].name, "_status"}, st, vecs[i].exp_status);
        end
        checkOutput("ignored_no_frame", 32'(rx_bits.size()), 32'h0);

        $display("[TB] single byte 0xA5");
        rx_bits.delete(); rx_bytes.delete();
        a5 = 8'hA5;
        writeByte(32'hFFFF_FFA5);
        @(negedge HCLK);
        checkOutput("a5_cs_n_plus1", 32'(SPI_CS_N), 32'h1);
        @(negedge HCLK);
        checkOutput("a5_cs_n_plus2", 32'(SPI_CS_N), 32'h0);
        cnt = 0;
        while (SPI_CS_N == 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge HCLK);
        end
        checkOutput("a5_cs_low_cycles", 32'(cnt), 32'd64);
        repeat (8) @(negedge HCLK);
        checkOutput("a5_bit_count", 32'(rx_bits.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("a5_bit%0d", i),
                        (i < rx_bits.size()) ? 32'(rx_bits[i]) : 32'hDEAD, 32'(a5[7-i]));
        end

        $display("[TB] six back-to-back writes");
        rx_bits.delete(); rx_bytes.delete();
        six[0] = 8'h81; six[1] = 8'h42; six[2] = 8'h3C;
        six[3] = 8'hFF; six[4] = 8'h00; six[5] = 8'h96;
        xq.delete();
        for (int i = 0; i < 6; i++) begin
            xq.push_back(mkx(1, 2'b10, 32'h5000_0010, 1, {24'h0, six[i]}, 1));
        end
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("b2b_waits_w%0d", i + 1), 32'(wait_res[i]), 32'd0);
        end
        checkOutput("b2b_waits_w6", 32'(wait_res[5]), 32'd66);
        readStatus(st);
        checkOutput("b2b_status_mid", st, 32'h0000_0043);
        repeat (400) @(negedge HCLK);
        checkOutput("b2b_byte_count", 32'(rx_bytes.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("b2b_byte%0d", i),
                        (i < rx_bytes.size()) ? 32'(rx_bytes[i]) : 32'hDEAD, 32'(six[i]));
        end
        readStatus(st);
        checkOutput("b2b_status_end", st, 32'h0000_0004);

        $display("[TB] reset mid-frame");
        writeByte(32'h5A);
        repeat (20) @(negedge HCLK);
        checkOutput("pre_reset_cs_n", 32'(SPI_CS_N), 32'h0);
        HRESET = 1'b1;
        #1;
        checkOutput("rst_cs_n_now", 32'(SPI_CS_N), 32'h1);
        checkOutput("rst_sclk_now", 32'(SPI_SCLK), 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        readStatus(st);
        checkOutput("rst_status_empty", st, 32'h0000_0004);
        rx_bits.delete(); rx_bytes.delete();
        writeByte(32'h3C);
        repeat (80) @(negedge HCLK);
        checkOutput("post_rst_byte_count", 32'(rx_bytes.size()), 32'd1);
        checkOutput("post_rst_byte", (rx_bytes.size() > 0) ? 32'(rx_bytes[0]) : 32'hDEAD,
                    32'h3C);
        readStatus(st);
        checkOutput("post_rst_status", st, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
